// File: rtl/fetch_inst_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_inst_buffer_pkg
// Brief    : Shared core configuration, branch type and fetch entry record
//            used by the fetch-to-decode instruction buffer.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef FETCH_BUF_DEPTH
`define FETCH_BUF_DEPTH 16
`endif

package fetch_inst_buffer_pkg;

  localparam int CFG_FETCH_WIDTH     = `FETCH_WIDTH;
  localparam int CFG_DECODE_WIDTH    = `DECODE_WIDTH;
  localparam int CFG_FETCH_BUF_DEPTH = `FETCH_BUF_DEPTH;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JUMP = 2'd2,
    BR_RET  = 2'd3
  } branch_type_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  inst;
    branch_type_t br_type;
    logic         pred_taken;
    logic         has_except;
  } fetch_entry_t;

  typedef logic [$clog2(CFG_FETCH_BUF_DEPTH)-1:0] fbuf_idx_t;

endpackage

`default_nettype wire

// File: rtl/fetch_inst_buffer_count_ones.sv
`default_nettype none
// ============================================================================
// Module   : fetch_inst_buffer_count_ones
// Brief    : Population count of a valid vector.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_inst_buffer_count_ones #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]               bits,
  output logic [$clog2(WIDTH+1)-1:0]     ones
);

  localparam int OW = $clog2(WIDTH + 1);

  // Sum every set bit of the input vector.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OW'(bits[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_inst_buffer
// Brief    : Circular instruction queue between fetch and decode. Accepts up
//            to FETCH_WIDTH entries per cycle, presents up to DECODE_WIDTH
//            oldest entries, and is flushed entirely on a squash.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH        = CFG_FETCH_BUF_DEPTH,
  parameter int FETCH_WIDTH  = CFG_FETCH_WIDTH,
  parameter int DECODE_WIDTH = CFG_DECODE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_squash_vld,
  input  logic [FETCH_WIDTH-1:0]               i_enq_vld,
  input  fetch_entry_t [FETCH_WIDTH-1:0]       i_enq_entry,
  output logic                                 o_can_enq,
  output logic [DECODE_WIDTH-1:0]              o_deq_vld,
  output fetch_entry_t [DECODE_WIDTH-1:0]      o_deq_entry,
  input  logic                                 i_deq_ready,
  output logic [$clog2(DEPTH):0]               o_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int EW = $clog2(FETCH_WIDTH + 1);
  localparam int DW = $clog2(DECODE_WIDTH + 1);

  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] free_slots;
  logic [EW-1:0] enq_ones;
  logic [DW-1:0] deq_ones;
  logic          enq_fire;
  logic          deq_fire;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_deq;

  fetch_entry_t  mem [DEPTH];

  fetch_inst_buffer_count_ones #(.WIDTH(FETCH_WIDTH)) u_enq_ones (
    .bits (i_enq_vld),
    .ones (enq_ones)
  );

  fetch_inst_buffer_count_ones #(.WIDTH(DECODE_WIDTH)) u_deq_ones (
    .bits (o_deq_vld),
    .ones (deq_ones)
  );

  // Space check uses current occupancy only, keeping decode ready off this path.
  always_comb begin
    free_slots = CW'(DEPTH) - count;
    o_can_enq  = (free_slots >= CW'(FETCH_WIDTH));
    enq_fire   = o_can_enq && (|i_enq_vld) && !i_squash_vld;
    deq_fire   = i_deq_ready && o_deq_vld[0] && !i_squash_vld;
    n_enq      = enq_fire ? CW'(enq_ones) : '0;
    n_deq      = deq_fire ? CW'(deq_ones) : '0;
  end

  // Decode lanes read straight from storage at head; no enqueue bypass.
  for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_deq
    assign o_deq_vld[k]   = (count > CW'(k));
    assign o_deq_entry[k] = mem[head + IW'(k)];
  end

  assign o_count = count;

  // Pointer and occupancy update; squash wins over enqueue and dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_squash_vld) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + IW'(n_deq);
      tail  <= tail + IW'(n_enq);
      count <= count + n_enq - n_deq;
    end
  end

  // Multi-lane storage write at tail plus lane offset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (i_enq_vld[k]) begin
          mem[tail + IW'(k)] <= i_enq_entry[k];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Occupancy bound, enqueue gating and contiguous fetch valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= CW'(DEPTH));
      assert (!(enq_fire && !o_can_enq));
      assert ((i_enq_vld & (i_enq_vld + FETCH_WIDTH'(1))) == '0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_inst_buffer
// Brief    : Directed self-checking bench for fetch_inst_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_inst_buffer;
  import fetch_inst_buffer_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    i_squash_vld;
  logic [3:0]              i_enq_vld;
  fetch_entry_t [3:0]      i_enq_entry;
  logic                    o_can_enq;
  logic [3:0]              o_deq_vld;
  fetch_entry_t [3:0]      o_deq_entry;
  logic                    i_deq_ready;
  logic [4:0]              o_count;

  int checks = 0;
  int errors = 0;

  fetch_inst_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .i_squash_vld (i_squash_vld),
    .i_enq_vld    (i_enq_vld),
    .i_enq_entry  (i_enq_entry),
    .o_can_enq    (o_can_enq),
    .o_deq_vld    (o_deq_vld),
    .o_deq_entry  (o_deq_entry),
    .i_deq_ready  (i_deq_ready),
    .o_count      (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] inst);
    fetch_entry_t e;
    e.pc         = 32'h8000_0000 + (inst << 2);
    e.inst       = inst;
    e.br_type    = BR_NONE;
    e.pred_taken = 1'b0;
    e.has_except = (inst == 32'h93);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [3:0] vld, input logic [31:0] base, input logic [31:0] stride);
    i_enq_vld = vld;
    for (int k = 0; k < 4; k++) i_enq_entry[k] = mk(base + stride * k);
  endtask

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];

  initial begin
    rst          = 1'b1;
    i_squash_vld = 1'b0;
    i_enq_vld    = 4'b0000;
    i_deq_ready  = 1'b0;
    for (int k = 0; k < 4; k++) i_enq_entry[k] = mk(32'h0);
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_can_enq", 32'(o_can_enq), 32'd1);
    check("rst_deq_vld", 32'(o_deq_vld), 32'h0);
    check("rst_count",   32'(o_count),   32'd0);

    // Single group of four, lane order, then full dequeue
    set_group(4'b1111, 32'h13, 32'h80);
    tick();
    i_enq_vld = 4'b0000;
    check("g1_deq_vld", 32'(o_deq_vld), 32'hF);
    check("g1_count",   32'(o_count),   32'd4);
    check("g1_lane0",   o_deq_entry[0].inst, 32'h13);
    check("g1_lane1",   o_deq_entry[1].inst, 32'h93);
    check("g1_lane2",   o_deq_entry[2].inst, 32'h113);
    check("g1_lane3",   o_deq_entry[3].inst, 32'h193);
    check("g1_exc1",    32'(o_deq_entry[1].has_except), 32'd1);
    check("g1_exc0",    32'(o_deq_entry[0].has_except), 32'd0);
    check("g1_pc3",     o_deq_entry[3].pc, 32'h8000_0000 + (32'h193 << 2));
    i_deq_ready = 1'b1;
    tick();
    i_deq_ready = 1'b0;
    check("g1_drained_count", 32'(o_count), 32'd0);
    check("g1_drained_vld",   32'(o_deq_vld), 32'h0);

    // Fill to 16 with decode stalled
    for (int g = 0; g < 4; g++) begin
      set_group(4'b1111, 32'h100 + 32'(4 * g), 32'd1);
      tick();
      check("fill_count", 32'(o_count), 32'(4 * (g + 1)));
    end
    check("full_can_enq", 32'(o_can_enq), 32'd0);
    set_group(4'b1111, 32'h200, 32'd1);
    tick();
    check("full_drop_count", 32'(o_count), 32'd16);
    check("full_head_lane0", o_deq_entry[0].inst, 32'h100);
    i_enq_vld   = 4'b0000;
    i_deq_ready = 1'b1;
    tick();
    check("release_count",   32'(o_count), 32'd12);
    check("release_can_enq", 32'(o_can_enq), 32'd1);
    for (int g = 1; g < 4; g++) begin
      for (int k = 0; k < 4; k++)
        check("drain_lane", o_deq_entry[k].inst, 32'h100 + 32'(4 * g + k));
      tick();
    end
    check("drain_count", 32'(o_count), 32'd0);

    // Wrap-around stream: 3+4+4+4+4 with decode always ready
    in_q.delete();
    out_q.delete();
    for (int c = 0; c < 30; c++) begin
      if (c < 5) begin
        if (c == 0) set_group(4'b0111, 32'h1000, 32'd1);
        else        set_group(4'b1111, 32'h1003 + 32'(4 * (c - 1)), 32'd1);
        for (int k = 0; k < 4; k++)
          if (i_enq_vld[k]) in_q.push_back(i_enq_entry[k].inst);
      end else begin
        i_enq_vld = 4'b0000;
      end
      if (o_deq_vld[0]) begin
        for (int k = 0; k < 4; k++)
          if (o_deq_vld[k]) out_q.push_back(o_deq_entry[k].inst);
      end
      tick();
      if (c >= 5 && o_count == 5'd0) break;
    end
    check("wrap_len", 32'(out_q.size()), 32'd19);
    for (int i = 0; i < 19; i++) begin
      if (i < out_q.size()) check("wrap_seq", out_q[i], 32'h1000 + 32'(i));
    end
    i_deq_ready = 1'b0;

    // Squash at count=10 with same-cycle enqueue and dequeue
    set_group(4'b1111, 32'h2000, 32'd1); tick();
    set_group(4'b1111, 32'h2004, 32'd1); tick();
    set_group(4'b0011, 32'h2008, 32'd1); tick();
    check("sq_pre_count", 32'(o_count), 32'd10);
    set_group(4'b1111, 32'hBAD0, 32'd1);
    i_deq_ready  = 1'b1;
    i_squash_vld = 1'b1;
    tick();
    i_squash_vld = 1'b0;
    i_deq_ready  = 1'b0;
    i_enq_vld    = 4'b0000;
    check("sq_count",   32'(o_count),   32'd0);
    check("sq_deq_vld", 32'(o_deq_vld), 32'h0);
    check("sq_can_enq", 32'(o_can_enq), 32'd1);
    check("sq_head",    32'(dut.head),  32'd0);
    check("sq_tail",    32'(dut.tail),  32'd0);
    set_group(4'b1111, 32'h3000, 32'd1);
    tick();
    i_enq_vld = 4'b0000;
    check("post_sq_count", 32'(o_count), 32'd4);
    for (int k = 0; k < 4; k++)
      check("post_sq_lane", o_deq_entry[k].inst, 32'h3000 + 32'(k));
    i_deq_ready = 1'b1;
    tick();
    i_deq_ready = 1'b0;
    check("post_sq_empty", 32'(o_count), 32'd0);

    // Enqueue 2 while dequeuing 3
    set_group(4'b0111, 32'h4000, 32'd1);
    tick();
    check("sim_pre_count", 32'(o_count), 32'd3);
    check("sim_pre_vld",   32'(o_deq_vld), 32'h7);
    set_group(4'b0011, 32'h5000, 32'd1);
    i_deq_ready = 1'b1;
    tick();
    i_deq_ready = 1'b0;
    i_enq_vld   = 4'b0000;
    check("sim_count", 32'(o_count),   32'd2);
    check("sim_vld",   32'(o_deq_vld), 32'h3);
    check("sim_lane0", o_deq_entry[0].inst, 32'h5000);
    check("sim_lane1", o_deq_entry[1].inst, 32'h5001);

    // Asynchronous reset mid-operation, then immediate enqueue
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(o_count),   32'd0);
    check("arst_vld",   32'(o_deq_vld), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_group(4'b0001, 32'h6000, 32'd1);
    tick();
    i_enq_vld = 4'b0000;
    check("arst_first_count", 32'(o_count), 32'd1);
    check("arst_first_lane0", o_deq_entry[0].inst, 32'h6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fetch_inst_buffer.md
Name: fetch_inst_buffer

Overview:
- Circular instruction queue between the fetch stage and decode.
- Accepts up to FETCH_WIDTH fetchEntry_t records per cycle from fetch and presents up to DECODE_WIDTH oldest entries per cycle to decode.
- Decouples fetch bubbles from decode backpressure.
- Flushed completely on any rob squash (squashInfo_t valid), since all buffered entries are younger than the squashing instruction.

Parameters:
- DEPTH, 16: entry count; power of two, >= FETCH_WIDTH + DECODE_WIDTH.
- FETCH_WIDTH, 4: enqueue lanes per cycle.
- DECODE_WIDTH, 4: dequeue lanes per cycle.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- i_squash_vld  in  1  squash from rob commit this cycle; flush everything
- i_enq_vld  in  FETCH_WIDTH  per-lane valid from fetch; lanes must be contiguous from lane 0
- i_enq_entry  in  FETCH_WIDTH x fetchEntry_t  fetched instructions, lane 0 oldest
- o_can_enq  out  1  buffer will accept a full FETCH_WIDTH group this cycle
- o_deq_vld  out  DECODE_WIDTH  per-lane valid to decode, contiguous from lane 0
- o_deq_entry  out  DECODE_WIDTH x fetchEntry_t  oldest entries, lane 0 oldest
- i_deq_ready  in  1  decode consumes all valid o_deq lanes this cycle (all-or-nothing)
- o_count  out  $clog2(DEPTH)+1  occupancy, for perf counters and debug

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset state: head=0, tail=0, count=0, o_can_enq=1, o_deq_vld=0, o_count=0. Storage contents are don't-care and need no reset.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. Lane k addresses (ptr+k) mod DEPTH.
- o_can_enq is registered-state derived: (DEPTH - count) >= FETCH_WIDTH.
  - It is computed from the current count only; same-cycle dequeue does not count as freed space.
  - This keeps the path off the decode ready chain.
- Enqueue fires when o_can_enq && |i_enq_vld && !i_squash_vld.
  - Writes popcount(i_enq_vld) entries at tail..tail+n-1.
  - tail += n.
  - Non-contiguous i_enq_vld is illegal; assert in simulation.
- Dequeue outputs are combinational from storage at head.
  - o_deq_vld[k] = (k < count).
  - Enqueue-to-visible latency is 1 cycle; no bypass from i_enq to o_deq.
- Dequeue fires when i_deq_ready && o_deq_vld[0] && !i_squash_vld.
  - head += popcount(o_deq_vld), i.e. min(count, DECODE_WIDTH).
- Count update: count_next = count + n_enq - n_deq. Enqueue and dequeue in the same cycle are legal, including when the buffer is full or empty.
- Squash has priority over everything.
  - The next state is head=0, tail=0, count=0.
  - Any same-cycle enqueue and dequeue are discarded.
  - o_deq_vld is 0 from the next cycle; o_can_enq is 1 from the next cycle.
  - Squash is combinationally masked from neither o_deq_vld nor o_can_enq; decode and fetch also see the squash and drop their own state.
- Empty: o_deq_vld=0, and i_deq_ready is ignored.
- Full (count=DEPTH): o_can_enq=0, and i_enq_vld is ignored.
- has_except entries are buffered and passed through like ordinary entries; no special handling here.
- Reset asserted mid-operation returns to the reset state immediately (asynchronous). The first enqueue is accepted in the first cycle after deassertion.
- Simulation assertions:
  - count <= DEPTH.
  - No enqueue when !o_can_enq.
  - Contiguous enqueue valids.

Decomposition:
- Shared package (alongside BranchType) holds:
  - fetchEntry_t (existing);
  - `FETCH_WIDTH, `DECODE_WIDTH and `FETCH_BUF_DEPTH macros in core_config;
  - typedef fbufIdx_t = logic [$clog2(DEPTH)-1:0].
- One natural sub-module: count_ones (popcount of a valid vector), reused for the enqueue and dequeue counts.
- Storage is a plain register array inside fetch_inst_buffer, with multi-port write by lane offset.

Test Plan:
- Reset → o_can_enq=1, o_deq_vld=0000, o_count=0.
- Enqueue 4 entries (inst 0x13,0x93,0x113,0x193) at cycle 1 → o_deq_vld=1111 at cycle 2, lane order preserved. With i_deq_ready=1 → o_count=0 at cycle 3.
- Fill to 16 with decode stalled (4 groups) → o_can_enq=0 at count=16. Fifth group dropped, count stays 16. Release i_deq_ready → count 12, o_can_enq=1 the next cycle.
- Wrap-around: enqueue 3+4+4+4+4 entries while dequeuing 4/cycle so tail crosses index 15→0 → output inst sequence matches input order exactly, with no duplication or loss.
- Squash with count=10 while i_enq_vld=1111 and i_deq_ready=1 → next cycle count=0, o_deq_vld=0, head=tail=0, and none of the same-cycle enqueued entries ever appears.
- Simultaneous enqueue of 2 (i_enq_vld=0011) and dequeue of 3 at count=3 → count=2 next cycle, o_deq_vld=0011 holding the two new entries.
